stream_rr_arbiter: RTL

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: locks one of N valid/ready input streams for a whole packet.
// Optional feature: define STREAM_ARB_PKT_CNT_EN to add a saturating 16-bit completed-packet counter (pkt_cnt_o).
module stream_rr_arbiter #(
   parameter int  N     = 4,
   parameter int  DATAW = 8,
   localparam int GW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N*DATAW-1:0]   s_data_i,
   input  logic [N-1:0]         s_valid_i,
   input  logic [N-1:0]         s_last_i,
   output logic [N-1:0]         s_ready_o,
   output logic [DATAW-1:0]     m_data_o,
   output logic                 m_valid_o,
   output logic                 m_last_o,
   input  logic                 m_ready_i,
   output logic [GW-1:0]        grant_o,
   output logic                 busy_o
`ifdef STREAM_ARB_PKT_CNT_EN
   ,
   output logic [15:0]          pkt_cnt_o
`endif
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    pick;
   logic             found;
   logic [GW:0]      sum;
   logic             g_valid;
   logic             g_last;
   logic [DATAW-1:0] g_data;
   logic             xfer;
   logic             xfer_last;

   // First valid port searching upward from ptr, wrapping modulo N.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (GW+1)'(i);
         if (sum >= (GW+1)'(N)) begin
            sum = sum - (GW+1)'(N);
         end
         if (!found && s_valid_i[sum[GW-1:0]]) begin
            found = 1'b1;
            pick  = sum[GW-1:0];
         end
      end
   end

   always_comb begin
      g_valid = s_valid_i[grant_q];
      g_last  = s_last_i[grant_q];
      g_data  = '0;
      for (int k = 0; k < N; k++) begin
         if (grant_q == GW'(k)) begin
            g_data = s_data_i[k*DATAW +: DATAW];
         end
      end
   end

   assign xfer      = (state_q == LOCKED) && g_valid && m_ready_i;
   assign xfer_last = xfer && g_last;

   always_comb begin
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_data_o  = '0;
      s_ready_o = '0;
      if (state_q == LOCKED) begin
         m_valid_o          = g_valid;
         m_last_o           = g_last;
         m_data_o           = g_data;
         s_ready_o[grant_q] = m_ready_i;
      end
   end

   // The lock is only released by a transferred last beat; a valid gap keeps it.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (xfer_last) begin
               state_d = IDLE;
               ptr_d   = (grant_q == GW'(N-1)) ? '0 : grant_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q == LOCKED);

`ifdef STREAM_ARB_PKT_CNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (xfer_last && (pkt_cnt_q != 16'hFFFF)) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
